// File: rtl/pst_scorer_pkg.sv
// Shared constants and FSM state type for the piece-square scorer.
package pst_scorer_pkg;

    localparam int DEF_VAL_W   = 6;
    localparam int DEF_SCORE_W = 13;
    localparam int NUM_SQ      = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/pst_rank_sum.sv
// Combinational masked sum of one rank (8 signed entries), sign-extended to SCORE_W.
module pst_rank_sum #(
    parameter int VAL_W   = 6,
    parameter int SCORE_W = 13
) (
    input  logic [8*VAL_W-1:0] vals_i,
    input  logic [7:0]         mask_i,
    output logic [SCORE_W-1:0] sum_o
);

    always_comb begin
        sum_o = '0;
        for (int f = 0; f < 8; f++) begin
            if (mask_i[f]) begin
                sum_o = sum_o + {{(SCORE_W-VAL_W){vals_i[f*VAL_W+VAL_W-1]}},
                                 vals_i[f*VAL_W +: VAL_W]};
            end
        end
    end

endmodule

// File: rtl/pst_scorer.sv
// Piece-square scorer: snapshots map and bitboards, then sums one rank per cycle
// over 8 cycles to produce white-minus-black score.
module pst_scorer
    import pst_scorer_pkg::*;
#(
    parameter int VAL_W   = DEF_VAL_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_SQ*VAL_W-1:0]   mapIn,
    input  logic [NUM_SQ-1:0]         whiteBB,
    input  logic [NUM_SQ-1:0]         blackBB,
    output logic                      busy,
    output logic                      done,
    output logic [SCORE_W-1:0]        score
);

    state_e                    state_q, state_d;
    logic [NUM_SQ*VAL_W-1:0]   map_q, map_d;
    logic [NUM_SQ-1:0]         white_q, white_d;
    logic [NUM_SQ-1:0]         black_q, black_d;
    logic [SCORE_W-1:0]        acc_q, acc_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic [2:0]                rank_q, rank_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [2:0]                black_row;
    logic [8*VAL_W-1:0]        white_vals, black_vals;
    logic [7:0]                white_mask, black_mask;
    logic [SCORE_W-1:0]        white_sum, black_sum;

    // Black pieces read the vertically mirrored map row (s ^ 56).
    assign black_row  = ~rank_q;
    assign white_vals = map_q[int'(rank_q) * 8 * VAL_W +: 8 * VAL_W];
    assign black_vals = map_q[int'(black_row) * 8 * VAL_W +: 8 * VAL_W];
    assign white_mask = white_q[int'(rank_q) * 8 +: 8];
    assign black_mask = black_q[int'(rank_q) * 8 +: 8];

    pst_rank_sum #(
        .VAL_W   (VAL_W),
        .SCORE_W (SCORE_W)
    ) u_white_sum (
        .vals_i (white_vals),
        .mask_i (white_mask),
        .sum_o  (white_sum)
    );

    pst_rank_sum #(
        .VAL_W   (VAL_W),
        .SCORE_W (SCORE_W)
    ) u_black_sum (
        .vals_i (black_vals),
        .mask_i (black_mask),
        .sum_o  (black_sum)
    );

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        white_d = white_q;
        black_d = black_q;
        acc_d   = acc_q;
        rank_d  = rank_q;
        score_d = score_q;
        unique case (state_q)
            // DONE accepts start like IDLE so passes can run back to back.
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    map_d   = mapIn;
                    white_d = whiteBB;
                    black_d = blackBB;
                    acc_d   = '0;
                    rank_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d  = acc_q + white_sum - black_sum;
                rank_d = rank_q + 3'd1;
                if (rank_q == 3'd7) begin
                    score_d = acc_d;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rank_q  <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rank_q  <= rank_d;
            score_q <= score_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Snapshot is pure datapath; only ever read while in RUN.
    always_ff @(posedge clk) begin
        map_q   <= map_d;
        white_q <= white_d;
        black_q <= black_d;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign score = score_q;

endmodule

// File: tb/tb_pst_scorer.sv
// Randomized self-checking bench for pst_scorer against a square-by-square reference model.
module tb_pst_scorer;

    localparam int VW = 6;
    localparam int SW = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [64*VW-1:0]  mapIn;
    logic [63:0]       whiteBB;
    logic [63:0]       blackBB;
    logic              busy;
    logic              done;
    logic [SW-1:0]     score;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pst_scorer #(
        .VAL_W   (VW),
        .SCORE_W (SW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mapIn   (mapIn),
        .whiteBB (whiteBB),
        .blackBB (blackBB),
        .busy    (busy),
        .done    (done),
        .score   (score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_score(logic [64*VW-1:0] m, logic [63:0] w, logic [63:0] b);
        int sc = 0;
        logic signed [VW-1:0] e;
        for (int s = 0; s < 64; s++) begin
            if (w[s]) begin
                e = m[VW*s +: VW];
                sc += int'(e);
            end
            if (b[s]) begin
                e = m[VW*(s ^ 56) +: VW];
                sc -= int'(e);
            end
        end
        return sc;
    endfunction

    function automatic logic [64*VW-1:0] rand_map();
        logic [64*VW-1:0] m;
        for (int i = 0; i < 64; i++) m[VW*i +: VW] = VW'($urandom);
        return m;
    endfunction

    function automatic logic [64*VW-1:0] fill_map(logic [VW-1:0] v);
        logic [64*VW-1:0] m;
        for (int i = 0; i < 64; i++) m[VW*i +: VW] = v;
        return m;
    endfunction

    function automatic int score_int();
        logic signed [SW-1:0] s;
        s = score;
        return int'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present inputs, pulse start over one edge, then scramble inputs to prove snapshotting.
    task automatic start_pass(input logic [64*VW-1:0] m, input logic [63:0] w,
                              input logic [63:0] b);
        mapIn   = m;
        whiteBB = w;
        blackBB = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        mapIn   = rand_map();
        whiteBB = {$urandom, $urandom};
        blackBB = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int k, output int busy_cnt);
        k = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && k < 20) begin
            tick();
            k++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        mapIn = rand_map();
        whiteBB = '1;
        blackBB = '1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (score !== '0) begin errors++; $display("FAIL reset_score: got %0d want 0", score_int()); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_map();
        int k, bc;
        start_pass(fill_map('0), '1, '1);
        wait_done(k, bc);
        checks++;
        if (k != 8) begin errors++; $display("FAIL zero_latency: got %0d want 8", k); end
        checks++;
        if (bc != 8) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 8", bc); end
        checks++;
        if (score_int() != 0) begin errors++; $display("FAIL zero_score: got %0d want 0", score_int()); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b want 0", done); end
    endtask

    task automatic test_directed();
        logic [64*VW-1:0] m;
        logic [63:0] w [5];
        logic [63:0] b [5];
        logic [64*VW-1:0] ms [5];
        int want [5];
        int k, bc;
        ms[0] = fill_map(6'd1);   w[0] = 64'hFF; b[0] = '0; want[0] = 8;
        m = fill_map('0);
        m[0 +: VW] = 6'b100000;
        m[VW*56 +: VW] = 6'd31;
        ms[1] = m;                w[1] = 64'h1;  b[1] = 64'h1; want[1] = -63;
        ms[2] = fill_map(6'd31);  w[2] = '1;     b[2] = '0;    want[2] = 1984;
        ms[3] = fill_map(6'b100000); w[3] = '0;  b[3] = '1;    want[3] = 2048;
        ms[4] = rand_map();       w[4] = '0;     b[4] = '0;    want[4] = 0;
        for (int i = 0; i < 5; i++) begin
            start_pass(ms[i], w[i], b[i]);
            wait_done(k, bc);
            checks++;
            if (k != 8 || score_int() != want[i]) begin
                errors++;
                $display("FAIL directed_%0d: got score %0d at %0d cycles want %0d at 8",
                         i, score_int(), k, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [64*VW-1:0] m;
        logic [63:0] w, b;
        int k, bc, want;
        for (int i = 0; i < 20; i++) begin
            m = rand_map();
            w = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 0) b = w;
            want = ref_score(m, w, b);
            start_pass(m, w, b);
            wait_done(k, bc);
            checks++;
            if (k != 8 || score_int() != want) begin
                errors++;
                $display("FAIL random_%0d: got score %0d at %0d cycles want %0d at 8",
                         i, score_int(), k, want);
            end
            // Score must hold through idle cycles.
            repeat ($urandom_range(2, 0)) tick();
            checks++;
            if (score_int() != want) begin
                errors++;
                $display("FAIL random_hold_%0d: got %0d want %0d", i, score_int(), want);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [64*VW-1:0] m;
        logic [63:0] w, b;
        int k, bc, want, extra;
        m = rand_map(); w = {$urandom, $urandom}; b = {$urandom, $urandom};
        want = ref_score(m, w, b);
        start_pass(m, w, b);
        tick();
        tick();
        start = 1'b1;
        mapIn = rand_map();
        tick();
        start = 1'b0;
        wait_done(k, bc);
        checks++;
        if (k != 5 || score_int() != want) begin
            errors++;
            $display("FAIL ignore_start_score: got %0d at +%0d want %0d at +5", score_int(), k, want);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL ignore_start_extra: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_pass(fill_map(6'd5), '1, '0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || score !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b score=%0d want 0 0 0", busy, done, score_int());
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0 || score !== '0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d active cycles score=%0d want 0 0", seen, score_int());
        end
    endtask

    task automatic test_back_to_back();
        logic [64*VW-1:0] m [5];
        logic [63:0] w [5];
        logic [63:0] b [5];
        int want, k, bc, last_done, t;
        for (int i = 0; i < 5; i++) begin
            m[i] = rand_map(); w[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom};
        end
        mapIn = m[0]; whiteBB = w[0]; blackBB = b[0];
        start = 1'b1;
        last_done = -1;
        for (int p = 0; p < 4; p++) begin
            t = 0;
            tick();
            while (!busy && t < 20) begin tick(); t++; end
            mapIn = m[p+1]; whiteBB = w[p+1]; blackBB = b[p+1];
            wait_done(k, bc);
            want = ref_score(m[p], w[p], b[p]);
            checks++;
            if (score_int() != want || !done) begin
                errors++;
                $display("FAIL b2b_score_%0d: got %0d want %0d", p, score_int(), want);
            end
            if (last_done >= 0) begin
                checks++;
                if (cyc - last_done != 9) begin
                    errors++;
                    $display("FAIL b2b_period_%0d: got %0d want 9", p, cyc - last_done);
                end
            end
            last_done = cyc;
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_map();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pst_scorer.md
PST_SCORER -- requirements
Module: pst_scorer

Interface
REQ-001 Parameter: VAL_W, 6, width of one signed piece-square entry.
REQ-002 Parameter: SCORE_W, 13, width of signed score output.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request one scoring pass; sampled only when busy=0.
REQ-006 Port: mapIn  input  64*VAL_W  flat piece-square map; square i occupies bits [VAL_W*i+VAL_W-1 : VAL_W*i], two's complement.
REQ-007 Port: whiteBB  input  64  white piece occupancy; bit i = square i.
REQ-008 Port: blackBB  input  64  black piece occupancy; bit i = square i.
REQ-009 Port: busy  output  1  high while a pass is in progress.
REQ-010 Port: done  output  1  single-cycle pulse; score valid.
REQ-011 Port: score  output  SCORE_W  signed result, white minus black.

Function
REQ-012 States IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 at edge N -> snapshot mapIn, whiteBB, blackBB into internal registers, clear accumulator, rank counter=0, go RUN.
REQ-014 Inputs changing after edge N do not affect the pass in progress.
REQ-015 RUN: each cycle processes one rank r (squares 8r..8r+7); accumulator += sum of map[s] for white bits set - sum of map[s^56] for black bits set (black mirrored vertically).
REQ-016 RUN lasts exactly 8 cycles (edges N+1..N+8); rank counter 3 bits, wraps 7->0 on exit.
REQ-017 At edge N+8: score register loaded with final accumulator, state -> DONE; done=1 for that one cycle only.
REQ-018 DONE: next edge -> IDLE unconditionally; start in DONE cycle is accepted (busy=0), giving back-to-back passes every 9 cycles.
REQ-019 busy=1 in RUN only; start while busy=1 is ignored, no queuing.
REQ-020 score holds its value from DONE until the next pass's DONE.
REQ-021 Entries sign-extended to SCORE_W before addition; range [-4032, 4032] fits 13 bits, no saturation needed.
REQ-022 White and black on the same square both count; no legality checking.
REQ-023 Empty bitboards give score 0.

Reset
REQ-024 reset=1 at any edge, including mid-RUN: state IDLE, busy=0, done=0, score=0, accumulator=0, rank=0; pass aborted, no done pulse.
REQ-025 reset has priority over start in the same cycle.

Structure
REQ-026 Shared package holds VAL_W, SCORE_W, square count 64, and state enum {IDLE, RUN, DONE}.
REQ-027 One sub-module pst_rank_sum: combinational masked sum of 8 signed VAL_W entries to SCORE_W, instantiated twice (white, black).
REQ-028 Map/bitboard snapshot, FSM, accumulator in pst_scorer; all outputs registered.

Verification
REQ-029 Map all 0, whiteBB=blackBB=all ones, start -> done at edge N+8, score=0, busy high exactly 8 cycles.
REQ-030 Map all +1, whiteBB=0x00000000000000FF, blackBB=0 -> score=8.
REQ-031 map[0]=-32, map[56]=+31, whiteBB=bit0, blackBB=bit0 -> score=-63 (black mirrors to square 56).
REQ-032 Map all +31, whiteBB=all ones, blackBB=0 -> 1984; map all -32, whiteBB=0, blackBB=all ones -> 2048.
REQ-033 start pulsed at RUN cycle 3 -> ignored, single done; reset at RUN cycle 5 -> busy=0, done never pulses, score=0.
REQ-034 start held high continuously -> done pulses every 9 cycles, each score matching the snapshot taken at its start.
